ht_cell_chain_tester: RTL and testbench

//   Parametrised on-chip tester for custom sequential cells. Builds a WIDTH-lane x DEPTH-stage flop chain
//   and pushes an LFSR pattern through it. A second, delayed LFSR checks every vector at the chain output.

---
 rtl/ht_celltest_pkg.sv | 20 ++
 rtl/ht_shift_chain.sv | 35 +++
 rtl/ht_cell_chain_tester.sv | 164 ++++++++++++++++
 tb/tb_ht_cell_chain_tester.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ht_celltest_pkg.sv
// Shared types and LFSR helpers for the cell-chain tester.
// Optional first-mismatch capture is enabled with HT_CELLTEST_FIRST_ERR_EN.
package ht_celltest_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ht_shift_chain.sv
// WIDTH-lane x DEPTH-stage register chain; the place where custom cells are swapped in.
// Shifts when en is high, holds otherwise, clears synchronously on RESET.
module ht_shift_chain #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    if (en) begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/ht_cell_chain_tester.sv
// On-chip tester: drives an LFSR pattern through ht_shift_chain and checks it with a delayed LFSR.
// Define HT_CELLTEST_FIRST_ERR_EN to add first_err_idx / first_err_lanes outputs.
import ht_celltest_pkg::*;

module ht_cell_chain_tester #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [LEN_W-1:0] n_vectors,
  input  logic [15:0]      seed,
  input  logic [WIDTH-1:0] inject,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] chain_out
`ifdef HT_CELLTEST_FIRST_ERR_EN
  ,
  output logic [LEN_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_lanes
`endif
);

  // Run counter must reach n_vectors+DEPTH-1 for the largest n_vectors.
  localparam int RUN_W = $clog2((1 << LEN_W) + DEPTH);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] n_q, n_d;
  logic [15:0]      gen_q, gen_d;
  logic [15:0]      chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             chain_en;
  logic [WIDTH-1:0] chain_in;
  logic [WIDTH-1:0] chain_q;
  logic [WIDTH-1:0] mism;
  logic [RUN_W-1:0] k_last;
  logic [15:0]      seed_eff;
`ifdef HT_CELLTEST_FIRST_ERR_EN
  logic [LEN_W-1:0] fe_idx_q, fe_idx_d;
  logic [WIDTH-1:0] fe_lanes_q, fe_lanes_d;
`endif

  ht_shift_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_chain (
    .CLK  (CLK),
    .RESET(RESET),
    .en   (chain_en),
    .d    (chain_in),
    .q    (chain_q)
  );

  assign seed_eff = (seed == 16'h0) ? DEFAULT_SEED : seed;
  assign mism     = chain_q ^ chk_q[WIDTH-1:0];
  assign k_last   = RUN_W'(n_q) + RUN_W'(DEPTH - 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    gen_d    = gen_q;
    chk_d    = chk_q;
    err_d    = err_q;
    chain_en = 1'b0;
    chain_in = '0;
`ifdef HT_CELLTEST_FIRST_ERR_EN
    fe_idx_d   = fe_idx_q;
    fe_lanes_d = fe_lanes_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FLUSH;
          cnt_d   = '0;
          n_d     = n_vectors;
          gen_d   = seed_eff;
          chk_d   = seed_eff;
          err_d   = '0;
`ifdef HT_CELLTEST_FIRST_ERR_EN
          fe_idx_d   = '0;
          fe_lanes_d = '0;
`endif
        end
      end
      FLUSH: begin
        chain_en = 1'b1;
        if (cnt_q == RUN_W'(DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        chain_en = 1'b1;
        if (cnt_q < RUN_W'(n_q)) begin
          chain_in = gen_q[WIDTH-1:0] ^ inject;
          gen_d    = lfsr_next(gen_q);
        end
        // Vector k-DEPTH reaches the chain output on this cycle
        if (cnt_q >= RUN_W'(DEPTH)) begin
          chk_d = lfsr_next(chk_q);
          if ((|mism) && !(&err_q)) err_d = err_q + 1'b1;
`ifdef HT_CELLTEST_FIRST_ERR_EN
          if ((|mism) && (fe_lanes_q == '0)) begin
            fe_idx_d   = LEN_W'(cnt_q - RUN_W'(DEPTH));
            fe_lanes_d = mism;
          end
`endif
        end
        if (cnt_q == k_last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      gen_q   <= '0;
      chk_q   <= '0;
      err_q   <= '0;
`ifdef HT_CELLTEST_FIRST_ERR_EN
      fe_idx_q   <= '0;
      fe_lanes_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      gen_q   <= gen_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
`ifdef HT_CELLTEST_FIRST_ERR_EN
      fe_idx_q   <= fe_idx_d;
      fe_lanes_q <= fe_lanes_d;
`endif
    end
  end

  assign busy      = (state_q == FLUSH) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign chain_out = chain_q;
`ifdef HT_CELLTEST_FIRST_ERR_EN
  assign first_err_idx   = fe_idx_q;
  assign first_err_lanes = fe_lanes_q;
`endif

endmodule

// File: tb/tb_ht_cell_chain_tester.sv
// Randomised self-checking bench for ht_cell_chain_tester (WIDTH=4, DEPTH=8, LEN_W=8),
// with a second instance at CNT_W=4 for counter saturation.
module tb_ht_cell_chain_tester;

  localparam int D = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [7:0]  n_vectors;
  logic [15:0] seed;
  logic [3:0]  inject;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [3:0]  chain_out;
  logic        busy_s, done_s, pass_s;
  logic [3:0]  err_s;
  logic [3:0]  chain_s;
`ifdef HT_CELLTEST_FIRST_ERR_EN
  logic [7:0]  fe_idx, fe_idx_s;
  logic [3:0]  fe_lanes, fe_lanes_s;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] inj_tbl [256];

  always #5 CLK = ~CLK;

  ht_cell_chain_tester #(.WIDTH(4), .DEPTH(D), .LEN_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .n_vectors(n_vectors), .seed(seed),
    .inject(inject), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .chain_out(chain_out)
`ifdef HT_CELLTEST_FIRST_ERR_EN
    , .first_err_idx(fe_idx), .first_err_lanes(fe_lanes)
`endif
  );

  ht_cell_chain_tester #(.WIDTH(4), .DEPTH(D), .LEN_W(8), .CNT_W(4)) dut_s (
    .CLK(CLK), .RESET(RESET), .start(start), .n_vectors(n_vectors), .seed(seed),
    .inject(inject), .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .chain_out(chain_s)
`ifdef HT_CELLTEST_FIRST_ERR_EN
    , .first_err_idx(fe_idx_s), .first_err_lanes(fe_lanes_s)
`endif
  );

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0
  function automatic logic [15:0] m_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic run_case(input string name, input int n, input logic [15:0] sd,
                          input logic [3:0] out_inj, input bit rand_out,
                          input int start_pulse_cyc, input int reset_cyc);
    logic [15:0] l;
    logic [3:0]  exp_vec [256];
    int          exp_err, exp_idx, exp_sat, done_cyc, cyc, k;
    logic [3:0]  exp_lanes;
    l = (sd == 16'h0) ? 16'hACE1 : sd;
    exp_err = 0; exp_idx = 0; exp_lanes = 4'h0;
    for (int j = 0; j < n; j++) begin
      exp_vec[j] = l[3:0] ^ inj_tbl[j];
      if (inj_tbl[j] != 4'h0) begin
        if (exp_err == 0) begin
          exp_idx = j;
          exp_lanes = inj_tbl[j];
        end
        exp_err++;
      end
      l = m_step(l);
    end
    exp_sat = (exp_err > 15) ? 15 : exp_err;

    @(negedge CLK);
    start = 1'b1; n_vectors = 8'(n); seed = sd; inject = out_inj;
    @(posedge CLK); #1;
    start = 1'b0; n_vectors = 8'($urandom); seed = 16'($urandom);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL %s start_latency: busy=%b done=%b, need busy=1 done=0", name, busy, done);
    else n_pass++;

    done_cyc = -1;
    cyc = 1;
    while (cyc <= 2*D + n + 10) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      k = cyc - 1 - D;
      if (k >= 0 && k < n) inject = inj_tbl[k];
      else inject = rand_out ? 4'($urandom) : out_inj;
      if (k >= D && k < n + D) begin
        n_checks++;
        if (chain_out !== exp_vec[k-D])
          $display("FAIL %s chain_out[v%0d]: got %h, need %h", name, k-D, chain_out, exp_vec[k-D]);
        else n_pass++;
      end
      start = (cyc == start_pulse_cyc);
      if (cyc == reset_cyc) RESET = 1'b1;
      @(posedge CLK); #1;
      if (RESET) begin
        RESET = 1'b0; start = 1'b0; inject = 4'h0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 16'h0 || chain_out !== 4'h0)
          $display("FAIL %s midrun_reset: busy=%b done=%b pass=%b err=%0d chain=%h, need all 0",
                   name, busy, done, pass, err_count, chain_out);
        else n_pass++;
        return;
      end
      cyc++;
    end
    inject = 4'h0;

    n_checks++;
    if (done_cyc !== 1 + 2*D + n)
      $display("FAIL %s done_time: got cycle %0d, need %0d", name, done_cyc, 1 + 2*D + n);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || pass !== (exp_err == 0))
      $display("FAIL %s verdict: busy=%b pass=%b, need busy=0 pass=%b", name, busy, pass, exp_err == 0);
    else n_pass++;
    n_checks++;
    if (err_count !== 16'(exp_err))
      $display("FAIL %s err_count: got %0d, need %0d", name, err_count, exp_err);
    else n_pass++;
    n_checks++;
    if (err_s !== 4'(exp_sat) || pass_s !== (exp_err == 0))
      $display("FAIL %s err_count_sat: got %0d pass=%b, need %0d pass=%b", name, err_s, pass_s,
               exp_sat, exp_err == 0);
    else n_pass++;
`ifdef HT_CELLTEST_FIRST_ERR_EN
    n_checks++;
    if (fe_idx !== 8'(exp_idx) || fe_lanes !== exp_lanes)
      $display("FAIL %s first_err: got idx=%0d lanes=%b, need idx=%0d lanes=%b", name, fe_idx,
               fe_lanes, exp_idx, exp_lanes);
    else n_pass++;
`endif
  endtask

  task automatic clear_tbl();
    for (int j = 0; j < 256; j++) inj_tbl[j] = 4'h0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b1; n_vectors = 8'd5; seed = 16'h0; inject = 4'hF;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 16'h0 || chain_out !== 4'h0)
      $display("FAIL reset_state: busy=%b done=%b pass=%b err=%0d chain=%h, need all 0",
               busy, done, pass, err_count, chain_out);
    else n_pass++;
`ifdef HT_CELLTEST_FIRST_ERR_EN
    n_checks++;
    if (fe_idx !== 8'h0 || fe_lanes !== 4'h0)
      $display("FAIL reset_first_err: idx=%0d lanes=%b, need 0", fe_idx, fe_lanes);
    else n_pass++;
`endif
    RESET = 1'b0; start = 1'b0; inject = 4'h0;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    clear_tbl();
    run_case("basic", 20, 16'h1234, 4'h0, 1'b0, 0, 0);
  endtask

  task automatic test_inject_held();
    for (int j = 0; j < 256; j++) inj_tbl[j] = 4'b0001;
    run_case("inject_held", 20, 16'h1234, 4'b0001, 1'b0, 0, 0);
  endtask

  task automatic test_single_glitch();
    clear_tbl();
    inj_tbl[5] = 4'b0100;
    run_case("single_glitch", 20, 16'h1234, 4'h0, 1'b0, 0, 0);
  endtask

  task automatic test_zero_vectors();
    clear_tbl();
    run_case("zero_vec", 0, 16'h0, 4'h0, 1'b0, 0, 0);
    run_case("zero_vec_rerun", 0, 16'h0, 4'h0, 1'b0, 0, 0);
  endtask

  task automatic test_start_ignored();
    clear_tbl();
    run_case("start_in_flush", 20, 16'h1234, 4'h0, 1'b0, 3, 0);
  endtask

  task automatic test_reset_midrun();
    clear_tbl();
    run_case("reset_midrun", 20, 16'h1234, 4'h0, 1'b0, 3, 1 + D + 10);
    run_case("after_reset", 20, 16'h1234, 4'h0, 1'b0, 0, 0);
  endtask

  task automatic test_saturate();
    for (int j = 0; j < 256; j++) inj_tbl[j] = 4'hF;
    run_case("saturate", 20, 16'h1234, 4'hF, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(60, 1);
      for (int j = 0; j < 256; j++)
        inj_tbl[j] = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'h0;
      run_case("random", n, 16'($urandom), 4'h0, 1'b1, 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    clear_tbl();
    run_case("b2b_a", 255, 16'hFFFF, 4'h0, 1'b1, 0, 0);
    inj_tbl[254] = 4'b1000;
    run_case("b2b_b", 255, 16'h0001, 4'h0, 1'b0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; start = 1'b0; n_vectors = 8'h0; seed = 16'h0; inject = 4'h0;
    test_reset();
    test_basic();
    test_inject_held();
    test_single_glitch();
    test_zero_vectors();
    test_start_ignored();
    test_reset_midrun();
    test_saturate();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
